// File: rtl/trackball_pkg.sv
// rtl/trackball_pkg.sv - shared constants, step type and quadrature step decode
// Purpose: common definitions for the trackball decoder and its per-axis slice.
//   QUAD_xx  : accepted {a,b} phase states in gray order 00->01->11->10.
//   ADDR_xx  : register-select codes on BA[1:0] for the trackball window.
//   step_t   : per-sample decode result.
//   quad_step: classifies a prev->curr phase transition.
package trackball_pkg;

    localparam logic [1:0] QUAD_00 = 2'b00;
    localparam logic [1:0] QUAD_01 = 2'b01;
    localparam logic [1:0] QUAD_11 = 2'b11;
    localparam logic [1:0] QUAD_10 = 2'b10;

    localparam logic [1:0] ADDR_X    = 2'd0;
    localparam logic [1:0] ADDR_Y    = 2'd1;
    localparam logic [1:0] ADDR_STAT = 2'd2;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        INC     = 2'd1,
        DEC     = 2'd2,
        ILLEGAL = 2'd3
    } step_t;

    // Forward successor in the gray cycle; the reverse direction is whatever
    // single-bit change is left once HOLD, INC and ILLEGAL are excluded.
    function automatic step_t quad_step(input logic [1:0] prev, input logic [1:0] curr);
        logic [1:0] fwd;
        case (prev)
            QUAD_00: fwd = QUAD_01;
            QUAD_01: fwd = QUAD_11;
            QUAD_11: fwd = QUAD_10;
            default: fwd = QUAD_00;
        endcase
        if (prev == curr)
            quad_step = HOLD;
        else if (curr == fwd)
            quad_step = INC;
        else if ((prev ^ curr) == 2'b11)
            quad_step = ILLEGAL;
        else
            quad_step = DEC;
    endfunction

endpackage

// File: rtl/trackball_quad_decoder_if.sv
// rtl/trackball_quad_decoder_if.sv - bus bundle between trackball pins/CPU window and decoder
// Purpose: groups the sample enable, raw quadrature pins, flip control, the
// CPU read port and the decoder outputs.
//   ce           : one-clk sample enable
//   x_a,x_b,y_a,y_b : raw asynchronous quadrature phases
//   flip         : 1 = negate both axis directions
//   addr, rd     : register select (BA[1:0]) and one-clk read strobe
//   data, err    : registered read byte and sticky illegal-transition flag
// master drives stimulus/CPU side, slave is the decoder.
interface trackball_quad_decoder_if;

    logic       ce;
    logic       x_a;
    logic       x_b;
    logic       y_a;
    logic       y_b;
    logic       flip;
    logic [1:0] addr;
    logic       rd;
    logic [7:0] data;
    logic       err;

    modport master (
        output ce, x_a, x_b, y_a, y_b, flip, addr, rd,
        input  data, err
    );

    modport slave (
        input  ce, x_a, x_b, y_a, y_b, flip, addr, rd,
        output data, err
    );

endinterface

// File: rtl/trackball_axis.sv
// rtl/trackball_axis.sv - one trackball axis: sync, glitch filter, 4x decode, wrap counter
// Purpose: turns one raw quadrature pair into an 8-bit wrapping position count.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   i_ce       : sample enable for filter, decode and counter
//   i_a, i_b   : raw asynchronous phases
//   i_flip     : registered flip; negates the counting direction
//   o_count    : position count
//   o_ab       : accepted (filtered) {a,b}
//   o_illegal  : one-clk pulse when both accepted bits changed in one sample
module trackball_axis
    import trackball_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_ce,
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_flip,
    output logic [7:0] o_count,
    output logic [1:0] o_ab,
    output logic       o_illegal
);

    // Run length at which a differing sample is accepted (counter counts 0..N-1).
    localparam logic [2:0] RUN_LAST = 3'(FILTER_LEN - 1);

    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_acc;
    logic [1:0] r_prev;
    logic [2:0] r_run [2];
    logic [7:0] r_count;

    step_t      w_step;
    logic       w_move;
    logic       w_up;

    // Two-flop synchroniser, runs every clk independent of i_ce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= {i_a, i_b};
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit run-length filter: a new level must persist for FILTER_LEN
    // consecutive samples; any sample matching the accepted level restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= 2'b00;
            r_run[0] <= 3'd0;
            r_run[1] <= 3'd0;
        end else if (i_ce) begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_acc[i]) begin
                    if (r_run[i] == RUN_LAST) begin
                        r_acc[i] <= r_sync2[i];
                        r_run[i] <= 3'd0;
                    end else begin
                        r_run[i] <= r_run[i] + 3'd1;
                    end
                end else begin
                    r_run[i] <= 3'd0;
                end
            end
        end
    end

    assign w_step = quad_step(r_prev, r_acc);
    assign w_move = (w_step == INC) || (w_step == DEC);
    assign w_up   = (w_step == INC) ^ i_flip;

    // prev follows the accepted pair every sample, so each accepted change is
    // decoded exactly once, one sample after it is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev  <= QUAD_00;
            r_count <= 8'h00;
        end else if (i_ce) begin
            r_prev <= r_acc;
            if (w_move) begin
                r_count <= w_up ? r_count + 8'd1 : r_count - 8'd1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_ab      = r_acc;
    assign o_illegal = i_ce && (w_step == ILLEGAL);

endmodule

// File: rtl/trackball_quad_decoder.sv
// rtl/trackball_quad_decoder.sv - two-axis trackball decoder with CPU read window
// Purpose: feeds the 0x9400-0x95FF trackball window. Two axis slices produce
// wrapping counts; this level holds flip, the sticky error flag and the
// registered read mux.
// Ports:
//   clk    : 10 MHz system clock
//   reset  : asynchronous active-high reset
//   bus    : slave side of trackball_quad_decoder_if
//            (ce, x/y phases, flip, addr, rd in; data, err out)
// Read map: 0 = X count, 1 = Y count,
//           2 = {err, flip_r, x_ab, y_ab, 2'b00}, 3 = 0xFF.
module trackball_quad_decoder
    import trackball_pkg::*;
#(
    parameter int FILTER_LEN   = 3,
    parameter bit FLIP_DEFAULT = 1'b0
) (
    input  logic                            clk,
    input  logic                            reset,
    trackball_quad_decoder_if.slave         bus
);

    logic [7:0] w_x_count;
    logic [7:0] w_y_count;
    logic [1:0] w_x_ab;
    logic [1:0] w_y_ab;
    logic       w_x_illegal;
    logic       w_y_illegal;

    logic       r_flip;
    logic       r_err;
    logic [7:0] r_data;

    trackball_axis #(.FILTER_LEN(FILTER_LEN)) u_axis_x (
        .clk       (clk),
        .reset     (reset),
        .i_ce      (bus.ce),
        .i_a       (bus.x_a),
        .i_b       (bus.x_b),
        .i_flip    (r_flip),
        .o_count   (w_x_count),
        .o_ab      (w_x_ab),
        .o_illegal (w_x_illegal)
    );

    trackball_axis #(.FILTER_LEN(FILTER_LEN)) u_axis_y (
        .clk       (clk),
        .reset     (reset),
        .i_ce      (bus.ce),
        .i_a       (bus.y_a),
        .i_b       (bus.y_b),
        .i_flip    (r_flip),
        .o_count   (w_y_count),
        .o_ab      (w_y_ab),
        .o_illegal (w_y_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flip <= FLIP_DEFAULT;
        end else if (bus.ce) begin
            r_flip <= bus.flip;
        end
    end

    // A new illegal transition takes priority over a clearing status read so
    // an error arriving in the same clk is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_x_illegal || w_y_illegal) begin
            r_err <= 1'b1;
        end else if (bus.rd && (bus.addr == ADDR_STAT)) begin
            r_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= 8'h00;
        end else begin
            case (bus.addr)
                ADDR_X:    r_data <= w_x_count;
                ADDR_Y:    r_data <= w_y_count;
                ADDR_STAT: r_data <= {r_err, r_flip, w_x_ab, w_y_ab, 2'b00};
                default:   r_data <= 8'hFF;
            endcase
        end
    end

    assign bus.data = r_data;
    assign bus.err  = r_err;

endmodule

// File: tb/tb_trackball_quad_decoder.sv
// tb/tb_trackball_quad_decoder.sv - directed self-checking bench for trackball_quad_decoder
module tb_trackball_quad_decoder;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    trackball_quad_decoder_if bus ();

    trackball_quad_decoder #(
        .FILTER_LEN   (3),
        .FLIP_DEFAULT (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #50 clk = ~clk;

    // ce: high for one clk out of every four.
    initial begin
        bus.ce = 1'b0;
        forever begin
            repeat (3) @(negedge clk) bus.ce = 1'b0;
            @(negedge clk) bus.ce = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Returns just after the n-th ce posedge.
    task automatic wait_ce(input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            @(posedge clk);
            while (!bus.ce && guard < 16) begin
                @(posedge clk);
                guard++;
            end
            if (guard >= 16) check("ce_timeout", 8'h00, 8'h01);
        end
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.rd   = 1'b1;
        @(negedge clk);
        bus.rd   = 1'b0;
        d        = bus.data;
    endtask

    task automatic set_x(input logic a, input logic b);
        wait_ce(1);
        @(negedge clk);
        bus.x_a = a;
        bus.x_b = b;
        wait_ce(4);
    endtask

    task automatic set_y(input logic a, input logic b);
        wait_ce(1);
        @(negedge clk);
        bus.y_a = a;
        bus.y_b = b;
        wait_ce(4);
    endtask

    task automatic x_fwd(input int steps);
        logic [1:0] seq [4];
        seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
        for (int i = 0; i < steps; i++) set_x(seq[i % 4][1], seq[i % 4][0]);
    endtask

    logic [7:0] d;

    initial begin
        bus.x_a = 0; bus.x_b = 0; bus.y_a = 0; bus.y_b = 0;
        bus.flip = 0; bus.addr = 2'd0; bus.rd = 0;

        repeat (3) @(negedge clk);
        check("reset_data", bus.data, 8'h00);
        check("reset_err", {7'd0, bus.err}, 8'h00);
        reset = 1'b0;

        rd_reg(2'd0, d); check("rst_x", d, 8'h00);
        rd_reg(2'd1, d); check("rst_y", d, 8'h00);
        rd_reg(2'd2, d); check("rst_stat", d, 8'h00);
        rd_reg(2'd3, d); check("addr3", d, 8'hFF);

        // 5 full forward cycles on X, then 4 reverse steps.
        x_fwd(20);
        wait_ce(2);
        rd_reg(2'd0, d); check("x_fwd20", d, 8'h14);
        rd_reg(2'd1, d); check("y_idle", d, 8'h00);
        set_x(1, 0); set_x(1, 1); set_x(0, 1); set_x(0, 0);
        wait_ce(2);
        rd_reg(2'd0, d); check("x_rev4", d, 8'h10);

        // Y underflow then forward wrap back up.
        set_y(1, 0);
        wait_ce(2);
        rd_reg(2'd1, d); check("y_wrap_ff", d, 8'hFF);
        set_y(0, 0); set_y(0, 1);
        wait_ce(2);
        rd_reg(2'd1, d); check("y_wrap_01", d, 8'h01);

        // Flip: forward pattern counts down.
        @(negedge clk); bus.flip = 1'b1;
        wait_ce(1);
        x_fwd(8);
        wait_ce(2);
        rd_reg(2'd0, d); check("x_flip", d, 8'h08);
        rd_reg(2'd2, d); check("stat_flip", d, 8'h44);
        @(negedge clk); bus.flip = 1'b0;
        wait_ce(1);

        // Glitch of 2 samples is rejected.
        wait_ce(1);
        @(negedge clk); bus.x_a = 1'b1;
        wait_ce(2);
        @(negedge clk); bus.x_a = 1'b0;
        wait_ce(3);
        rd_reg(2'd0, d); check("glitch2_x", d, 8'h08);
        rd_reg(2'd2, d); check("glitch2_stat", d, 8'h04);

        // 3 samples is accepted: 00 -> 10 decodes as a reverse step.
        wait_ce(1);
        @(negedge clk); bus.x_a = 1'b1;
        wait_ce(3);
        rd_reg(2'd2, d); check("glitch3_stat", d, 8'h24);
        wait_ce(2);
        rd_reg(2'd0, d); check("glitch3_x", d, 8'h07);
        set_x(0, 0);
        wait_ce(2);
        rd_reg(2'd0, d); check("x_back", d, 8'h08);

        // Illegal jump on Y: 01 -> 10.
        set_y(1, 0);
        wait_ce(2);
        check("ill_err", {7'd0, bus.err}, 8'h01);
        rd_reg(2'd1, d); check("ill_y", d, 8'h01);
        rd_reg(2'd2, d); check("ill_stat", d, 8'h88);
        check("err_cleared", {7'd0, bus.err}, 8'h00);

        // Illegal 10 -> 01 lands on the same edge as a clearing read.
        wait_ce(1);
        @(negedge clk); bus.y_a = 1'b0; bus.y_b = 1'b1;
        wait_ce(3);
        repeat (4) @(negedge clk);
        check("pre_collide_err", {7'd0, bus.err}, 8'h00);
        bus.addr = 2'd2; bus.rd = 1'b1;
        @(negedge clk); bus.rd = 1'b0;
        check("set_wins", {7'd0, bus.err}, 8'h01);
        rd_reg(2'd2, d); check("stat_after", d, 8'h84);
        check("err_clear2", {7'd0, bus.err}, 8'h00);
        rd_reg(2'd1, d); check("y_after_ill", d, 8'h01);

        // Reset mid-operation.
        @(negedge clk); reset = 1'b1;
        #1;
        check("midrst_data", bus.data, 8'h00);
        @(negedge clk); bus.x_a = 0; bus.x_b = 0; bus.y_a = 0; bus.y_b = 0;
        @(negedge clk); reset = 1'b0;
        wait_ce(2);
        rd_reg(2'd0, d); check("midrst_x", d, 8'h00);
        rd_reg(2'd1, d); check("midrst_y", d, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
